// File: rtl/bus_slave_port.sv
// Slave endpoint of the 1-bit serial interconnect: deserialises address/write data, accesses a local
// word memory and serialises read data back. Split-read support is compiled in with BUS_SLAVE_SPLIT_EN.
module bus_slave_port #(
    parameter int ADDR_WIDTH    = 12,
    parameter int DATA_WIDTH    = 8,
    parameter int MEM_DEPTH     = 4096,
    parameter int SPLIT_LATENCY = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic wdata,
    input  logic mode,
    input  logic mvalid,
    output logic rdata,
    output logic svalid,
    output logic ready,
    output logic split,
    input  logic split_grant
);
    localparam int CNT_MAX = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int AW1     = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0]    ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0]    DATA_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
    localparam logic [ADDR_WIDTH:0] DEPTH_C   = AW1'(MEM_DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        WDATA  = 3'd2,
        WRITE  = 3'd3,
        RFETCH = 3'd4,
`ifdef BUS_SLAVE_SPLIT_EN
        SPLIT  = 3'd5,
`endif
        RDATA  = 3'd6
    } state_e;

    state_e                  state_q, state_d;
    logic                    mode_q, mode_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    ready_q, ready_d;
    logic                    svalid_q, svalid_d;
    logic [DATA_WIDTH-1:0]   rshift_q;
    logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];
    logic [IDX_W-1:0]        mem_idx;
    logic                    in_range;
    logic                    mem_we;
    logic                    rd_load;

`ifdef BUS_SLAVE_SPLIT_EN
    localparam int SPL_W = $clog2(SPLIT_LATENCY + 1);
    localparam logic [SPL_W-1:0] SPL_LAST = SPL_W'(SPLIT_LATENCY - 1);

    logic [SPL_W-1:0]        spl_cnt_q, spl_cnt_d;
    logic                    gnt_q, gnt_d;
    logic                    split_q, split_d;
    logic [DATA_WIDTH-1:0]   hold_q;
`else
    localparam int split_latency_unused = SPLIT_LATENCY;
    logic unused_split_grant;
    assign unused_split_grant = split_grant;
`endif

    // Addresses beyond the implemented depth read as zero and drop writes.
    assign mem_idx  = addr_q[IDX_W-1:0];
    assign in_range = ({1'b0, addr_q} < DEPTH_C);
    assign mem_we   = (state_q == WRITE) && in_range && !rst;
    assign rd_load  = (state_d == RDATA) && (state_q != RDATA);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
`ifdef BUS_SLAVE_SPLIT_EN
        spl_cnt_d = spl_cnt_q;
        gnt_d     = gnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (mvalid) begin
                    mode_d  = mode;
                    addr_d  = {wdata, addr_q[ADDR_WIDTH-1:1]};
                    cnt_d   = CNT_ONE;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (mvalid) begin
                    addr_d = {wdata, addr_q[ADDR_WIDTH-1:1]};
                    cnt_d  = cnt_q + CNT_ONE;
                    if (cnt_q == ADDR_LAST) begin
                        cnt_d   = '0;
                        state_d = mode_q ? WDATA : RFETCH;
                    end
                end
            end
            WDATA: begin
                if (mvalid) begin
                    data_d = {wdata, data_q[DATA_WIDTH-1:1]};
                    cnt_d  = cnt_q + CNT_ONE;
                    if (cnt_q == DATA_LAST) begin
                        cnt_d   = '0;
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            RFETCH: begin
                cnt_d = '0;
`ifdef BUS_SLAVE_SPLIT_EN
                spl_cnt_d = '0;
                gnt_d     = 1'b0;
                state_d   = SPLIT;
`else
                state_d   = RDATA;
`endif
            end
`ifdef BUS_SLAVE_SPLIT_EN
            // After the grant is seen, one cycle with split low precedes the data burst.
            SPLIT: begin
                if (gnt_q) begin
                    gnt_d   = 1'b0;
                    state_d = RDATA;
                end else if (spl_cnt_q == SPL_LAST) begin
                    if (split_grant) begin
                        gnt_d = 1'b1;
                    end
                end else begin
                    spl_cnt_d = spl_cnt_q + 1'b1;
                end
            end
`endif
            RDATA: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == DATA_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ready_d  = (state_d == IDLE);
    assign svalid_d = (state_d == RDATA);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mode_q   <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            svalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            svalid_q <= svalid_d;
        end
    end

`ifdef BUS_SLAVE_SPLIT_EN
    assign split_d = (state_d == SPLIT) && !gnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            spl_cnt_q <= '0;
            gnt_q     <= 1'b0;
            split_q   <= 1'b0;
        end else begin
            spl_cnt_q <= spl_cnt_d;
            gnt_q     <= gnt_d;
            split_q   <= split_d;
        end
    end
`endif

    // Word memory: write port plus registered read (held across the split wait when enabled).
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_idx] <= data_q;
        end
`ifdef BUS_SLAVE_SPLIT_EN
        if (state_q == RFETCH) begin
            hold_q <= mem_q[mem_idx];
        end
`endif
    end

    // Read shift register; zero-fill means rdata returns to 0 once the burst ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            rshift_q <= '0;
        end else if (rd_load) begin
`ifdef BUS_SLAVE_SPLIT_EN
            rshift_q <= in_range ? hold_q : '0;
`else
            rshift_q <= in_range ? mem_q[mem_idx] : '0;
`endif
        end else if (state_q == RDATA) begin
            rshift_q <= {1'b0, rshift_q[DATA_WIDTH-1:1]};
        end
    end

    assign rdata  = rshift_q[0];
    assign svalid = svalid_q;
    assign ready  = ready_q;
`ifdef BUS_SLAVE_SPLIT_EN
    assign split  = split_q;
`else
    assign split  = 1'b0;
`endif

endmodule
